// File: rtl/layered_colorizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : layered_colorizer
//  Description : Two-stage pixel colorizer. Stage 1 looks up the world-code
//                palette and picks the highest-priority visible icon layer.
//                Stage 2 selects black / icon / palette color.
//                A 6-bit frame counter drives per-layer blink phase, and the
//                palette can be rewritten at any time.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                enableVideo         - visible-region flag
//                worldIn             - world-map code of current pixel
//                layerIcon           - packed icon colors, layer k at
//                                      [k*COLOR_W +: COLOR_W], 0 = transparent
//                blinkEn             - per-layer blink enable
//                frameTick           - one-cycle frame-start pulse
//                palWe/palAddr/palData - palette write port
//                drawColor/drawValid - registered pixel color and valid
//  Revision    : 1.0 - initial release
// ============================================================================
module layered_colorizer #(
    parameter int COLOR_W   = 12,
    parameter int WORLD_W   = 2,
    parameter int N_LAYERS  = 2,
    parameter int BLINK_BIT = 4     // legal range 0..5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enableVideo,
    input  logic [WORLD_W-1:0]           worldIn,
    input  logic [N_LAYERS*COLOR_W-1:0]  layerIcon,
    input  logic [N_LAYERS-1:0]          blinkEn,
    input  logic                         frameTick,
    input  logic                         palWe,
    input  logic [WORLD_W-1:0]           palAddr,
    input  logic [COLOR_W-1:0]           palData,
    output logic [COLOR_W-1:0]           drawColor,
    output logic                         drawValid
);

    localparam int c_PAL_DEPTH = 1 << WORLD_W;
    localparam int c_FIELD_W   = COLOR_W / 3;

    // Mask with c_FIELD_W ones starting at bit lsb.
    function automatic logic [COLOR_W-1:0] f_field_mask(input int lsb);
        logic [COLOR_W-1:0] m;
        m = '0;
        for (int b = 0; b < COLOR_W; b++) begin
            if (b >= lsb && b < lsb + c_FIELD_W) m[b] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [COLOR_W-1:0] c_RED   = f_field_mask(COLOR_W - c_FIELD_W);
    localparam logic [COLOR_W-1:0] c_GREEN = f_field_mask(COLOR_W - 2*c_FIELD_W);

    // Power-up palette reproduces the legacy map: white, black, red, green.
    function automatic logic [COLOR_W-1:0] f_reset_color(input int idx);
        case (idx)
            0:       return '1;
            2:       return c_RED;
            3:       return c_GREEN;
            default: return '0;
        endcase
    endfunction

    logic [c_PAL_DEPTH*COLOR_W-1:0] r_pal;
    logic [5:0]                     r_frame_cnt;

    logic [COLOR_W-1:0] r_s1_pal;
    logic [COLOR_W-1:0] r_s1_icon;
    logic               r_s1_hit;
    logic               r_s1_en;

    logic               w_blink_phase;
    logic [COLOR_W-1:0] w_icon;
    logic               w_hit;

    assign w_blink_phase = r_frame_cnt[BLINK_BIT];

    // Walk from lowest priority to highest so the lowest visible index wins.
    always_comb begin
        w_icon = '0;
        w_hit  = 1'b0;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if ((layerIcon[k*COLOR_W +: COLOR_W] != '0) &&
                !(blinkEn[k] && w_blink_phase)) begin
                w_icon = layerIcon[k*COLOR_W +: COLOR_W];
                w_hit  = 1'b1;
            end
        end
    end

    // Palette: the stage-1 read below samples the pre-write contents, so a
    // same-edge write is seen only by later lookups.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_PAL_DEPTH; i++) begin
                r_pal[i*COLOR_W +: COLOR_W] <= f_reset_color(i);
            end
        end else if (palWe) begin
            r_pal[palAddr*COLOR_W +: COLOR_W] <= palData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (frameTick) begin
            r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    // Stage 1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_pal  <= '0;
            r_s1_icon <= '0;
            r_s1_hit  <= 1'b0;
            r_s1_en   <= 1'b0;
        end else begin
            r_s1_pal  <= r_pal[worldIn*COLOR_W +: COLOR_W];
            r_s1_icon <= w_icon;
            r_s1_hit  <= w_hit;
            r_s1_en   <= enableVideo;
        end
    end

    // Stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            drawColor <= '0;
            drawValid <= 1'b0;
        end else begin
            drawValid <= r_s1_en;
            if (!r_s1_en)      drawColor <= '0;
            else if (r_s1_hit) drawColor <= r_s1_icon;
            else               drawColor <= r_s1_pal;
        end
    end

endmodule
`default_nettype wire
